// File: rtl/multi_edge_detector_pkg.sv
// multi_edge_detector_pkg: default sizing and latency helper for the multi-channel edge detector
package multi_edge_detector_pkg;
  localparam int DEF_NUM_CH      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_W  = 4;
  function automatic int latency(input int sync_stages, input int debounce_len);
    return sync_stages + debounce_len + 1;
  endfunction
endpackage

// File: rtl/edge_debounce_ch.sv
// edge_debounce_ch: one channel of synchroniser, debounce filter, stable level and edge pulses
module edge_debounce_ch
  import multi_edge_detector_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  sample_in,
  input  logic [DEBOUNCE_W-1:0] debounce_len,
  output logic                  level,
  output logic                  rise,
  output logic                  fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic [DEBOUNCE_W-1:0]  cnt;
  logic                   s;
  assign s = sync[SYNC_STAGES-1];
  // synchronise, then accept a change only after it has been stable for debounce_len extra cycles
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sample_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt >= debounce_len) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= !s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/multi_edge_detector.sv
// multi_edge_detector: NUM_CH debounced edge detectors; sticky pending/IRQ when MULTI_EDGE_DETECTOR_STICKY_EN is defined
module multi_edge_detector
  import multi_edge_detector_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_W  = DEF_DEBOUNCE_W
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [NUM_CH-1:0]     SAMPLE_IN,
  input  logic [DEBOUNCE_W-1:0] DEBOUNCE_LEN,
  output logic [NUM_CH-1:0]     LEVEL_OUT,
  output logic [NUM_CH-1:0]     RISE_EDGE_OUT,
  output logic [NUM_CH-1:0]     FALL_EDGE_OUT,
  input  logic [NUM_CH-1:0]     EVENT_CLEAR,
  output logic [NUM_CH-1:0]     EVENT_PENDING,
  output logic                  IRQ_OUT
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    edge_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_ch (
      .CLK         (CLK),
      .RSTN        (RSTN),
      .sample_in   (SAMPLE_IN[i]),
      .debounce_len(DEBOUNCE_LEN),
      .level       (LEVEL_OUT[i]),
      .rise        (RISE_EDGE_OUT[i]),
      .fall        (FALL_EDGE_OUT[i])
    );
  end
`ifdef MULTI_EDGE_DETECTOR_STICKY_EN
  // sticky edge flags where a new edge beats a simultaneous clear; IRQ is their registered OR
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      EVENT_PENDING <= '0;
      IRQ_OUT       <= 1'b0;
    end else begin
      EVENT_PENDING <= (EVENT_PENDING & ~EVENT_CLEAR) | RISE_EDGE_OUT | FALL_EDGE_OUT;
      IRQ_OUT       <= |EVENT_PENDING;
    end
  end
`else
  logic unused_clear;
  assign unused_clear  = ^EVENT_CLEAR;
  assign EVENT_PENDING = '0;
  assign IRQ_OUT       = 1'b0;
`endif
endmodule
